// File: rtl/spu_pkg.sv
// spu_pkg: shared state encoding, register map and bit positions for the SPU event counter.
package spu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_ASID   = 4'd1;
    localparam logic [3:0] REG_WINDOW = 4'd2;
    localparam logic [3:0] REG_THRESH = 4'd3;
    localparam logic [3:0] REG_CNT0   = 4'd4;
    localparam logic [3:0] REG_STATUS = 4'd8;

    localparam int CTRL_START    = 0;
    localparam int CTRL_STOP     = 1;
    localparam int CTRL_CLEAR    = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_PRIV_LSB = 4;
    localparam int CTRL_ASID_EN  = 7;

    localparam int STAT_DONE    = 2;
    localparam int STAT_OVF_LSB = 8;
    localparam int STAT_HIT_LSB = 16;

    localparam logic [1:0] PRIV_M = 2'b01;
    localparam logic [1:0] PRIV_S = 2'b10;
    localparam logic [1:0] PRIV_U = 2'b11;

endpackage

// File: rtl/spu_event_cnt.sv
// spu_event_cnt: one wrapping event counter with overflow and threshold-hit sticky flags.
module spu_event_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 clr_i,
    input  logic                 ovf_clr_i,
    input  logic                 hit_clr_i,
    input  logic [31:0]          thresh_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o,
    output logic                 hit_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 ovf_q, ovf_d, hit_q, hit_d;

    // Sticky flags: a same-cycle set beats the W1C, but CLEAR beats everything.
    always_comb begin
        cnt_inc = cnt_q + CNT_WIDTH'(1);
        cnt_d   = clr_i ? '0 : inc_i ? cnt_inc : cnt_q;
        ovf_d   = ~clr_i & ((inc_i & (&cnt_q)) | (ovf_q & ~ovf_clr_i));
        hit_d   = ~clr_i & ((inc_i & (thresh_i != '0) & (32'(cnt_inc) == thresh_i)) | (hit_q & ~hit_clr_i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            hit_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            hit_q <= hit_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
    assign hit_o = hit_q;

endmodule

// File: rtl/spu_event_counter.sv
// spu_event_counter: filters core event-unit cycles and counts qualified events per line over a window.
module spu_event_counter
    import spu_pkg::*;
#(
    parameter int   NUM_EVENTS = 4,
    parameter int   CNT_WIDTH  = 32,
    parameter int   ASID_WIDTH = 16,
    parameter logic SPU_ID     = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_EVENTS-1:0] e_id_i,
    input  logic [ASID_WIDTH+1:0] e_info_i,
    input  logic                  s_id_i,
    input  logic                  cfg_req_i,
    input  logic                  cfg_we_i,
    input  logic [3:0]            cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    output logic [31:0]           cfg_rdata_o,
    output logic                  cfg_rvalid_o,
    output logic                  irq_o,
    output logic                  busy_o
);

    state_e               state_q, state_d;
    logic [31:0]          win_q, win_d;
    logic                 done_q, done_d, done_set;
    logic [7:0]           ctrl_q;
    logic [31:0]          asid_q, window_q, thresh_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q;
    logic                 wr, rd, wr_ctrl, w1c, start, stop, clear;
    logic [1:0]           priv;
    logic [2:0]           pmask;
    logic                 qual;
    logic [NUM_EVENTS-1:0] ovf, hit;
    logic [CNT_WIDTH-1:0] cnt [NUM_EVENTS];

    always_comb begin
        wr      = cfg_req_i & cfg_we_i;
        rd      = cfg_req_i & ~cfg_we_i;
        wr_ctrl = wr & (cfg_addr_i == REG_CTRL);
        w1c     = wr & (cfg_addr_i == REG_STATUS);
        start   = wr_ctrl & cfg_wdata_i[CTRL_START];
        stop    = wr_ctrl & cfg_wdata_i[CTRL_STOP];
        clear   = wr_ctrl & cfg_wdata_i[CTRL_CLEAR];
        priv    = e_info_i[ASID_WIDTH +: 2];
        pmask   = ctrl_q[CTRL_PRIV_LSB +: 3];
        qual    = (state_q == ST_RUN)
                & ((priv == PRIV_M & pmask[0]) | (priv == PRIV_S & pmask[1]) | (priv == PRIV_U & pmask[2]))
                & (~ctrl_q[CTRL_ASID_EN] | (e_info_i[ASID_WIDTH-1:0] == asid_q[ASID_WIDTH-1:0]))
                & (s_id_i == SPU_ID);
    end

    // A loaded window of 0 means run until STOP; otherwise the cycle seeing 1 is the last counted one.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        done_set = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start & ~stop) begin
                    state_d = ST_RUN;
                    win_d   = window_q;
                end
            end
            ST_RUN: begin
                if (stop | (win_q == 32'd1)) begin
                    state_d  = ST_DONE;
                    done_set = 1'b1;
                end else if (win_q != '0) begin
                    win_d = win_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = ~clear & (done_set | (done_q & ~(w1c & cfg_wdata_i[STAT_DONE])));
    end

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cnt
        spu_event_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .inc_i     (qual & e_id_i[i]),
            .clr_i     (clear),
            .ovf_clr_i (w1c & cfg_wdata_i[STAT_OVF_LSB+i]),
            .hit_clr_i (w1c & cfg_wdata_i[STAT_HIT_LSB+i]),
            .thresh_i  (thresh_q),
            .cnt_o     (cnt[i]),
            .ovf_o     (ovf[i]),
            .hit_o     (hit[i])
        );
    end

    always_comb begin
        rdata_d = '0;
        if (cfg_addr_i == REG_CTRL)   rdata_d = 32'(ctrl_q);
        if (cfg_addr_i == REG_ASID)   rdata_d = asid_q;
        if (cfg_addr_i == REG_WINDOW) rdata_d = window_q;
        if (cfg_addr_i == REG_THRESH) rdata_d = thresh_q;
        if (cfg_addr_i == REG_STATUS)
            rdata_d = 32'(state_q) | (32'(done_q) << STAT_DONE)
                    | (32'(ovf) << STAT_OVF_LSB) | (32'(hit) << STAT_HIT_LSB);
        for (int k = 0; k < NUM_EVENTS; k++)
            if (cfg_addr_i == REG_CNT0 + 4'(k)) rdata_d = 32'(cnt[k]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            done_q   <= 1'b0;
            ctrl_q   <= '0;
            asid_q   <= '0;
            window_q <= '0;
            thresh_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            done_q   <= done_d;
            if (wr_ctrl) ctrl_q <= {cfg_wdata_i[7:3], 3'b000};
            if (wr & (cfg_addr_i == REG_ASID))   asid_q   <= cfg_wdata_i;
            if (wr & (cfg_addr_i == REG_WINDOW)) window_q <= cfg_wdata_i;
            if (wr & (cfg_addr_i == REG_THRESH)) thresh_q <= cfg_wdata_i;
            rdata_q  <= rd ? rdata_d : '0;
            rvalid_q <= rd;
        end
    end

    assign cfg_rdata_o  = rdata_q;
    assign cfg_rvalid_o = rvalid_q;
    assign irq_o        = ctrl_q[CTRL_IRQ_EN] & (done_q | (|hit));
    assign busy_o       = (state_q == ST_RUN);

endmodule

// File: tb/tb_spu_event_counter.sv
// tb_spu_event_counter: directed and randomized checks of spu_event_counter against a cycle model.
module tb_spu_event_counter;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  e_id;
    logic [17:0] e_info;
    logic        s_id;
    logic        cfg_req, cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cfg_rvalid, irq, busy;

    int checks = 0;
    int errors = 0;

    int          m_state, m_win;
    int          m_cnt [4];
    bit          m_ovf [4];
    bit          m_hit [4];
    bit          m_done;
    bit [31:0]   m_ctrl, m_asid, m_window, m_thresh;
    bit [31:0]   exp_rdata;
    bit          exp_rvalid;

    spu_event_counter #(.NUM_EVENTS(4), .CNT_WIDTH(CW), .ASID_WIDTH(16), .SPU_ID(1'b0)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .e_id_i       (e_id),
        .e_info_i     (e_info),
        .s_id_i       (s_id),
        .cfg_req_i    (cfg_req),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_rdata_o  (cfg_rdata),
        .cfg_rvalid_o (cfg_rvalid),
        .irq_o        (irq),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] m_read(input bit [3:0] a);
        bit [31:0] s;
        case (a)
            4'd0: return m_ctrl;
            4'd1: return m_asid;
            4'd2: return m_window;
            4'd3: return m_thresh;
            4'd4, 4'd5, 4'd6, 4'd7: return 32'(m_cnt[a-4]);
            4'd8: begin
                s = 32'(m_state);
                s[2] = m_done;
                for (int i = 0; i < 4; i++) begin
                    s[8+i]  = m_ovf[i];
                    s[16+i] = m_hit[i];
                end
                return s;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_irq();
        bit h;
        h = 0;
        for (int i = 0; i < 4; i++) h |= m_hit[i];
        return m_ctrl[3] && (m_done || h);
    endfunction

    // Applies one clock of the specified behaviour to the model, given the inputs now being driven.
    task automatic m_step();
        bit wr, start, stop, clr, w1c, q, done_set;
        bit [1:0] pv;
        if (rst) begin
            m_state = 0; m_win = 0; m_done = 0;
            m_ctrl = 0; m_asid = 0; m_window = 0; m_thresh = 0;
            for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; m_hit[i] = 0; end
            exp_rvalid = 0;
            return;
        end
        wr    = cfg_req && cfg_we;
        start = wr && cfg_addr == 0 && cfg_wdata[0];
        stop  = wr && cfg_addr == 0 && cfg_wdata[1];
        clr   = wr && cfg_addr == 0 && cfg_wdata[2];
        w1c   = wr && cfg_addr == 8;
        exp_rvalid = cfg_req && !cfg_we;
        if (exp_rvalid) exp_rdata = m_read(cfg_addr);
        pv = e_info[17:16];
        q = m_state == 1 && pv != 0 && m_ctrl[3+pv] && (!m_ctrl[7] || e_info[15:0] == m_asid[15:0]) && s_id == 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w1c && cfg_wdata[8+i])  m_ovf[i] = 0;
            if (w1c && cfg_wdata[16+i]) m_hit[i] = 0;
            if (q && e_id[i]) begin
                m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
                if (m_cnt[i] == 0) m_ovf[i] = 1;
                if (m_thresh != 0 && m_thresh == 32'(m_cnt[i])) m_hit[i] = 1;
            end
            if (clr) begin m_cnt[i] = 0; m_ovf[i] = 0; m_hit[i] = 0; end
        end
        done_set = 0;
        if (m_state == 1) begin
            if (stop || m_win == 1) begin m_state = 2; done_set = 1; end
            else if (m_win != 0) m_win--;
        end else if (start && !stop) begin
            m_state = 1;
            m_win = int'(m_window);
        end
        if (w1c && cfg_wdata[2]) m_done = 0;
        if (done_set) m_done = 1;
        if (clr) m_done = 0;
        if (wr && cfg_addr == 0) m_ctrl = {24'd0, cfg_wdata[7:3], 3'b000};
        if (wr && cfg_addr == 1) m_asid = cfg_wdata;
        if (wr && cfg_addr == 2) m_window = cfg_wdata;
        if (wr && cfg_addr == 3) m_thresh = cfg_wdata;
    endtask

    task automatic cyc();
        m_step();
        @(negedge clk);
        cfg_req = 0;
        cfg_we  = 0;
    endtask

    task automatic wr(input bit [3:0] a, input bit [31:0] d);
        cfg_req = 1; cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        cyc();
    endtask

    task automatic rd(input bit [3:0] a);
        cfg_req = 1; cfg_we = 0; cfg_addr = a;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        checks++;
        if (irq !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: irq=%b busy=%b, expected 0 0", irq, busy);
        end
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            checks++;
            if (cfg_rvalid !== 1'b1 || cfg_rdata !== 32'd0) begin
                errors++;
                $display("FAIL reset_read[%0d]: rvalid=%b rdata=%h, expected 1 00000000", a, cfg_rvalid, cfg_rdata);
            end
        end
        cyc();
        checks++;
        if (cfg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_pulse: rvalid=%b, expected 0", cfg_rvalid);
        end
    endtask

    task automatic test_window();
        int exp_c [4] = '{10, 0, 10, 0};
        wr(2, 32'd10);
        wr(0, 32'h11);
        e_id = 4'b0101; e_info = {2'b01, 16'h1234}; s_id = 0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            checks++;
            if (busy !== (m_state == 1)) begin
                errors++;
                $display("FAIL window_busy[%0d]: busy=%b, expected %b", k, busy, m_state == 1);
            end
        end
        e_id = 0;
        for (int i = 0; i < 4; i++) begin
            rd(4'(4 + i));
            checks++;
            if (cfg_rdata !== 32'(exp_c[i])) begin
                errors++;
                $display("FAIL window_cnt[%0d]: got %0d, expected %0d", i, cfg_rdata, exp_c[i]);
            end
        end
        rd(8);
        checks++;
        if (cfg_rdata !== 32'h6) begin
            errors++;
            $display("FAIL window_status: got %h, expected 00000006", cfg_rdata);
        end
    endtask

    task automatic test_asid_filter();
        wr(0, 32'h4);
        wr(1, 32'd5);
        wr(2, 32'd0);
        wr(0, 32'h91);
        e_id = 4'b0001; s_id = 0;
        for (int k = 0; k < 8; k++) begin
            e_info = {2'b01, (k % 2) ? 16'd6 : 16'd5};
            cyc();
        end
        e_info = {2'b00, 16'd5};
        repeat (3) cyc();
        e_info = {2'b01, 16'd5}; s_id = 1;
        repeat (3) cyc();
        e_id = 0; s_id = 0;
        rd(4);
        checks++;
        if (cfg_rdata !== 32'd4) begin
            errors++;
            $display("FAIL asid_cnt0: got %0d, expected 4", cfg_rdata);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL asid_busy: busy=%b, expected 1", busy);
        end
        wr(0, 32'h2);
    endtask

    task automatic test_wrap();
        wr(0, 32'h4);
        wr(2, 32'd0);
        wr(0, 32'h11);
        e_id = 4'b0010; e_info = {2'b01, 16'd9}; s_id = 0;
        repeat (17) cyc();
        e_id = 0;
        rd(5);
        checks++;
        if (cfg_rdata !== 32'd1) begin
            errors++;
            $display("FAIL wrap_cnt1: got %0d, expected 1", cfg_rdata);
        end
        rd(8);
        checks++;
        if (cfg_rdata !== 32'h201) begin
            errors++;
            $display("FAIL wrap_status_run: got %h, expected 00000201", cfg_rdata);
        end
        wr(0, 32'h2);
        rd(8);
        checks++;
        if (cfg_rdata !== 32'h206 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_stop: status=%h busy=%b, expected 00000206 0", cfg_rdata, busy);
        end
    endtask

    task automatic test_thresh_irq();
        wr(0, 32'h4);
        wr(3, 32'd3);
        wr(0, 32'h19);
        e_id = 4'b0001; e_info = {2'b01, 16'd0}; s_id = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (irq !== (k == 2)) begin
                errors++;
                $display("FAIL thresh_irq[%0d]: irq=%b, expected %b", k, irq, k == 2);
            end
        end
        e_id = 0;
        rd(8);
        checks++;
        if (cfg_rdata !== 32'h10001) begin
            errors++;
            $display("FAIL thresh_status: got %h, expected 00010001", cfg_rdata);
        end
        wr(8, 32'h10000);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL hit_w1c_irq: irq=%b, expected 0", irq);
        end
        wr(0, 32'h0A);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL done_irq: irq=%b, expected 1", irq);
        end
        wr(8, 32'h4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL done_w1c_irq: irq=%b, expected 0", irq);
        end
    endtask

    task automatic test_clear_start();
        wr(2, 32'd20);
        wr(0, 32'h11);
        e_id = 4'b1111; e_info = {2'b01, 16'd0}; s_id = 0;
        repeat (5) cyc();
        wr(0, 32'h14);
        e_id = 0;
        for (int i = 0; i < 4; i++) begin
            rd(4'(4 + i));
            checks++;
            if (cfg_rdata !== 32'd0) begin
                errors++;
                $display("FAIL clear_cnt[%0d]: got %0d, expected 0", i, cfg_rdata);
            end
        end
        wr(0, 32'h11);
        e_id = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            cyc();
            checks++;
            if (busy !== (k < 8)) begin
                errors++;
                $display("FAIL start_ignored_busy[%0d]: busy=%b, expected %b", k, busy, k < 8);
            end
        end
        e_id = 0;
        rd(4);
        checks++;
        if (cfg_rdata !== 32'd9) begin
            errors++;
            $display("FAIL start_ignored_cnt0: got %0d, expected 9", cfg_rdata);
        end
    endtask

    task automatic test_random();
        int r;
        wr(0, 32'h4);
        wr(1, 32'd5);
        wr(3, 32'd7);
        for (int k = 0; k < 400; k++) begin
            e_id   = 4'($urandom);
            e_info = {2'($urandom), $urandom_range(0, 1) ? 16'd5 : 16'd6};
            s_id   = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 19);
            cfg_req = (r < 10); cfg_we = (r < 3);
            cfg_addr  = (r == 0) ? 4'd0 : (r == 1) ? 4'd2 : (r == 2) ? 4'd8 : 4'($urandom_range(0, 9));
            cfg_wdata = (r == 0) ? ($urandom & 32'hFF) : (r == 1) ? 32'($urandom_range(0, 30)) : $urandom;
            cyc();
            checks++;
            if (busy !== (m_state == 1) || irq !== m_irq() || cfg_rvalid !== exp_rvalid) begin
                errors++;
                $display("FAIL random_ctl[%0d]: busy=%b irq=%b rvalid=%b, expected %b %b %b",
                         k, busy, irq, cfg_rvalid, m_state == 1, m_irq(), exp_rvalid);
            end
            if (exp_rvalid) begin
                checks++;
                if (cfg_rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL random_rdata[%0d]: got %h, expected %h", k, cfg_rdata, exp_rdata);
                end
            end
        end
    endtask

    initial begin
        rst = 1; e_id = 0; e_info = 0; s_id = 0;
        cfg_req = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
        @(negedge clk);
        test_reset();
        test_window();
        test_asid_filter();
        test_wrap();
        test_thresh_irq();
        test_clear_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spu_event_counter.md
# spu_event_counter

Receiving end of the SPU event interface. Samples the per-cycle event vector (`e_id`), event context (`e_info` = {priv code, ASID}) and source ID (`s_id`) driven by the core's event unit, qualifies each cycle against programmable privilege/ASID/source filters, and accumulates one counter per event line over a programmable window. Counters, status and interrupt are exposed through a simple synchronous register port on the SPU side.

## Interface
- `NUM_EVENTS`, default 4: event lines, width of `e_id_i`.
- `CNT_WIDTH`, default 32: per-line counter width (≤32).
- `ASID_WIDTH`, default 16: ASID field width in `e_info_i`.
- `SPU_ID`, default 1'b0: `s_id_i` value accepted.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock; reset is synchronous and active-high.
- `e_id_i` in NUM_EVENTS: event bits, one per line, valid every cycle.
- `e_info_i` in ASID_WIDTH+2: {priv[1:0], asid}; priv 01=M, 10=S, 11=U, 00 unmapped.
- `s_id_i` in 1: source ID.
- `cfg_req_i` in 1: register access request, single cycle.
- `cfg_we_i` in 1: 1 write, 0 read.
- `cfg_addr_i` in 4: word index.
- `cfg_wdata_i` in 32: write data.
- `cfg_rdata_o` out 32: read data, registered.
- `cfg_rvalid_o` out 1: read data valid, one-cycle pulse.
- `irq_o` out 1: level interrupt.
- `busy_o` out 1: high in RUN.

## Operation
- Register map (word): 0 CTRL, 1 ASID_MATCH, 2 WINDOW, 3 THRESH, 4..4+NUM_EVENTS-1 CNT[i] (RO, zero-extended), 8 STATUS.
- CTRL: bit0 START, bit1 STOP, bit2 CLEAR (self-clearing, read as 0); bit3 IRQ_EN; bits6:4 priv mask (M,S,U); bit7 ASID_EN. Reset 0.
- STATUS: bits1:0 state, bit2 DONE, bits 8+i OVF[i], bits 16+i HIT[i]; bits 2, 8+, 16+ write-1-to-clear.
- FSM IDLE(0) / RUN(1) / DONE(2). START in IDLE or DONE → RUN, load window counter with WINDOW; START in RUN ignored. STOP in RUN → DONE. In RUN with WINDOW≠0, window counter decrements each cycle; cycle where it equals 1 is last counted cycle, then DONE and DONE flag set. WINDOW=0 → unbounded until STOP. STOP/START in same write: STOP wins.
- Qualify = state RUN ∧ priv mask bit for `e_info_i` priv code (00 never qualifies) ∧ (¬ASID_EN ∨ asid = ASID_MATCH[ASID_WIDTH-1:0]) ∧ `s_id_i` = SPU_ID.
- Per line i: if qualify ∧ `e_id_i[i]`, CNT[i] += 1, wrapping at 2^CNT_WIDTH; wrap sets OVF[i]. If THRESH≠0 and post-increment CNT[i] = THRESH, set HIT[i].
- CLEAR: zero all CNT, OVF, HIT, DONE; state unchanged; beats same-cycle increment.
- `irq_o` = IRQ_EN ∧ (DONE ∨ |HIT).
- Writes to unmapped/RO addresses ignored; reads of unmapped addresses return 0. Filter writes during RUN take effect next cycle.

## Timing
- Reset: all registers, counters, state (IDLE) and outputs 0; reset mid-RUN discards counts.
- Event at cycle t → CNT updated at edge ending t; read requested at t+1 returns it.
- Read: `cfg_rvalid_o`/`cfg_rdata_o` valid the cycle after request; back-to-back reads allowed.
- Write at cycle t: control effective at edge ending t; first counted cycle after START is t+1; STOP at t → cycle t still counted if RUN, DONE from t+1.
- HIT/OVF/DONE set and `irq_o` rises the cycle after the triggering event; W1C on a bit being set in the same cycle: set wins.

## Structure
- `spu_pkg`: state enum, register index constants, CTRL/STATUS bit positions, priv code constants.
- Sub-module `spu_event_cnt`: one counter with enable, clear, wrap/OVF and threshold/HIT; instantiated NUM_EVENTS times.

## Test plan
- Reset then read all registers → all 0, `irq_o`=0, `busy_o`=0.
- Priv mask=M, WINDOW=10, START; drive e_id=4'b0101, priv=01 for 15 cycles → CNT0=CNT2=10, CNT1=CNT3=0, DONE=1, state=2.
- ASID_EN=1, ASID_MATCH=5; alternate asid 5/6 for 8 cycles with e_id=1 → CNT0=4; priv 00 or s_id≠SPU_ID cycles → no count.
- CNT_WIDTH=4, WINDOW=0: 17 events on line 1 → CNT1=1, OVF1=1; STOP → DONE.
- THRESH=3, IRQ_EN=1: third event → HIT0, `irq_o`=1 next cycle; W1C HIT0 → `irq_o`=0.
- CLEAR on same cycle as event, and START during RUN → counters 0, window unaffected by the ignored START.
